db_qp_map: RTL and testbench

- Generates the per-4x4 deblocking QP map for one LCU.
- Consumes a raster-ordered stream of 4x4 blocks carrying per-channel cbf and the coded CU QP. Emits, per block:
  - qp_flag: the QP is replaced by the left neighbour's QP.
  - eff_qp: the QP deblocking must use.
- Successor of the single-block qp-flag register. Adds:
  - NUM_CH cbf channels.
  - Left-neighbour tracking inside the LCU and across LCUs via a column buffer.
  - valid/ready handshakes and an LCU start/done FSM.
- Sits between the CU info fetch and the deblocking boundary-strength/filter stage.

---
 rtl/db_pkg.sv | 7 +
 rtl/db_qp_colbuf.sv | 21 ++
 rtl/db_qp_map.sv | 86 ++++++++
 tb/tb_db_qp_map.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// db_pkg: shared defaults and FSM encoding for the deblocking QP map.
package db_pkg;
    localparam int LCU_W4_D = 16;
    localparam int NUM_CH_D = 3;
    localparam int QP_W_D   = 6;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/db_qp_colbuf.sv
// db_qp_colbuf: per-row effective QP of the rightmost 4x4 column, kept across LCUs.
module db_qp_colbuf #(
    parameter int LCU_W4 = 16,
    parameter int QP_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [$clog2(LCU_W4)-1:0] wa,
    input  logic [QP_W-1:0]           wd,
    input  logic [$clog2(LCU_W4)-1:0] ra,
    output logic [QP_W-1:0]           rd
);
    logic [QP_W-1:0] mem [LCU_W4];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < LCU_W4; i++) mem[i] <= '0;
        else if (we)
            mem[wa] <= wd;
    assign rd = mem[ra];
endmodule

// File: rtl/db_qp_map.sv
// db_qp_map: per-4x4 deblocking QP map; all-zero-cbf blocks inherit the left neighbour's QP.
module db_qp_map import db_pkg::*; #(
    parameter int LCU_W4 = LCU_W4_D,
    parameter int NUM_CH = NUM_CH_D,
    parameter int QP_W   = QP_W_D
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      left_avail_i,
    input  logic                      blk_valid_i,
    output logic                      blk_ready_o,
    input  logic [NUM_CH-1:0]         cbf_i,
    input  logic [QP_W-1:0]           qp_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      qp_flag_o,
    output logic [QP_W-1:0]           eff_qp_o,
    output logic [$clog2(LCU_W4)-1:0] x_o,
    output logic [$clog2(LCU_W4)-1:0] y_o,
    output logic                      busy_o,
    output logic                      done_o
);
    localparam int AW = $clog2(LCU_W4);
    localparam logic [AW-1:0] LAST = AW'(LCU_W4 - 1);
    state_t          state;
    logic [AW-1:0]   x, y;
    logic            lav, acc, flag;
    logic [QP_W-1:0] col_qp, eq;
    assign blk_ready_o = (state == RUN) && (!out_valid_o || out_ready_i);
    assign acc         = blk_valid_i && blk_ready_o;
    // eff_qp_o always holds the previously accepted block, i.e. the left neighbour when x>0
    assign flag        = ~|cbf_i && ((x != '0) || lav);
    assign eq          = !flag ? qp_i : (x != '0) ? eff_qp_o : col_qp;
    assign busy_o      = state != IDLE;
    assign done_o      = (state == DONE) && out_valid_o && out_ready_i;
    db_qp_colbuf #(.LCU_W4(LCU_W4), .QP_W(QP_W)) u_colbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (acc && (x == LAST)),
        .wa    (y),
        .wd    (eq),
        .ra    (y),
        .rd    (col_qp)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            lav         <= 1'b0;
            out_valid_o <= 1'b0;
            qp_flag_o   <= 1'b0;
            eff_qp_o    <= '0;
            x_o         <= '0;
            y_o         <= '0;
        end else begin
            if (acc) begin
                out_valid_o <= 1'b1;
                qp_flag_o   <= flag;
                eff_qp_o    <= eq;
                x_o         <= x;
                y_o         <= y;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            case (state)
                IDLE: if (start_i) begin
                    state <= RUN;
                    x     <= '0;
                    y     <= '0;
                    lav   <= left_avail_i;
                end
                RUN: if (acc) begin
                    x <= (x == LAST) ? '0 : x + AW'(1);
                    if (x == LAST) begin
                        y <= (y == LAST) ? '0 : y + AW'(1);
                        if (y == LAST) state <= DONE;
                    end
                end
                DONE: if (out_valid_o && out_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_db_qp_map.sv
// tb_db_qp_map: randomized handshake bench with an array-based QP-map reference model.
module tb_db_qp_map;
    localparam int W = 4;
    localparam int N = W * W;
    logic clk = 0, rst_n = 0, start = 0, lav_i = 0, blk_valid = 0, out_ready = 0;
    logic [2:0] cbf = 0;
    logic [0:0] cbf1 = 0;
    logic [5:0] qp = 0;
    logic blk_ready, out_valid, qp_flag, busy, done;
    logic [5:0] eff_qp;
    logic [1:0] xo, yo;
    logic blk_ready1, out_valid1, qp_flag1, busy1, done1;
    logic [5:0] eff_qp1;
    logic [1:0] xo1, yo1;
    int checks = 0, failures = 0;
    logic [2:0] cbf_a [N];
    logic       cbf1_a [N];
    logic [5:0] qp_a [N];
    logic [5:0] cb0 [W], cb1 [W];
    logic       obs_flag [N];
    logic [5:0] obs_qp [N];

    always #5 clk = ~clk;

    db_qp_map #(.LCU_W4(W), .NUM_CH(3), .QP_W(6)) u0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .left_avail_i(lav_i),
        .blk_valid_i(blk_valid), .blk_ready_o(blk_ready), .cbf_i(cbf), .qp_i(qp),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .qp_flag_o(qp_flag),
        .eff_qp_o(eff_qp), .x_o(xo), .y_o(yo), .busy_o(busy), .done_o(done));

    db_qp_map #(.LCU_W4(W), .NUM_CH(1), .QP_W(6)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .left_avail_i(lav_i),
        .blk_valid_i(blk_valid), .blk_ready_o(blk_ready1), .cbf_i(cbf1), .qp_i(qp),
        .out_valid_o(out_valid1), .out_ready_i(out_ready), .qp_flag_o(qp_flag1),
        .eff_qp_o(eff_qp1), .x_o(xo1), .y_o(yo1), .busy_o(busy1), .done_o(done1));

    task automatic rand_blocks();
        for (int i = 0; i < N; i++) begin
            cbf_a[i]  = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(0, 7));
            cbf1_a[i] = $urandom_range(0, 2) == 0;
            qp_a[i]   = 6'($urandom_range(0, 63));
        end
    endtask

    // rmode: 0 = always ready, 1 = random ready, 2 = five-cycle stall after two outputs
    task automatic run_lcu(input bit la, input int rmode, input bit rnd_start);
        bit ef0 [N], ef1 [N];
        logic [5:0] eq0 [N], eq1 [N];
        int sent, got, cyc, stall, idx;
        bit hold, pf;
        logic [5:0] pq;
        logic [1:0] px, py;
        for (int i = 0; i < N; i++) begin
            int cx = i % W, cy = i / W;
            bit av = (cx > 0) ? 1'b1 : la;
            ef0[i] = (cbf_a[i] == 0) && av;
            ef1[i] = (cbf1_a[i] == 0) && av;
            eq0[i] = ef0[i] ? ((cx > 0) ? eq0[i-1] : cb0[cy]) : qp_a[i];
            eq1[i] = ef1[i] ? ((cx > 0) ? eq1[i-1] : cb1[cy]) : qp_a[i];
            if (cx == W - 1) begin
                cb0[cy] = eq0[i];
                cb1[cy] = eq1[i];
            end
        end
        @(negedge clk);
        start = 1; lav_i = la; blk_valid = 1; out_ready = 1;
        cbf = cbf_a[0]; cbf1 = cbf1_a[0]; qp = qp_a[0];
        #1;
        checks++;
        if (blk_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b want=0", blk_ready); end
        @(negedge clk);
        start = 0; blk_valid = 0;
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_run got=%b want=1", busy); end
        sent = 0; got = 0; cyc = 0; stall = 0; hold = 0; pf = 0; pq = 0; px = 0; py = 0;
        while (got < N && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (rmode == 2 && got == 2 && stall < 5) begin
                out_ready = 0;
                stall++;
            end else begin
                out_ready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            blk_valid = (sent < N) && (rmode != 1 || $urandom_range(0, 3) != 0);
            idx = (sent < N) ? sent : N - 1;
            cbf = cbf_a[idx]; cbf1 = cbf1_a[idx]; qp = qp_a[idx];
            start = rnd_start && ($urandom_range(0, 5) == 0);
            lav_i = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (blk_ready !== ((sent < N) && (!out_valid || out_ready))) begin
                failures++; $display("FAIL blk_ready sent=%0d got=%b", sent, blk_ready);
            end
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || {qp_flag, eff_qp, xo, yo} !== {pf, pq, px, py}) begin
                    failures++;
                    $display("FAIL hold_stable got=%b/%0d/(%0d,%0d) want=%b/%0d/(%0d,%0d)",
                             qp_flag, eff_qp, xo, yo, pf, pq, px, py);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (qp_flag !== ef0[got] || eff_qp !== eq0[got] || xo !== 2'(got % W) || yo !== 2'(got / W)) begin
                    failures++;
                    $display("FAIL out_blk%0d got=%b/%0d/(%0d,%0d) want=%b/%0d/(%0d,%0d)", got,
                             qp_flag, eff_qp, xo, yo, ef0[got], eq0[got], got % W, got / W);
                end
                checks++;
                if (out_valid1 !== 1'b1 || qp_flag1 !== ef1[got] || eff_qp1 !== eq1[got]) begin
                    failures++;
                    $display("FAIL ch1_blk%0d got=%b/%b/%0d want=1/%b/%0d", got,
                             out_valid1, qp_flag1, eff_qp1, ef1[got], eq1[got]);
                end
                checks++;
                if (done !== (got == N - 1)) begin
                    failures++; $display("FAIL done_pulse blk=%0d got=%b want=%b", got, done, got == N - 1);
                end
                obs_flag[got] = qp_flag;
                obs_qp[got] = eff_qp;
                got++;
            end else begin
                checks++;
                if (done !== 1'b0) begin failures++; $display("FAIL done_spurious got=%b want=0", done); end
            end
            hold = out_valid && !out_ready;
            pf = qp_flag; pq = eff_qp; px = xo; py = yo;
            if (blk_valid && blk_ready) sent++;
        end
        start = 0; blk_valid = 0;
        checks++;
        if (got != N) begin failures++; $display("FAIL lcu_timeout got=%0d want=%0d", got, N); end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL idle_after busy=%b valid=%b want=0/0", busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        checks++;
        if ({blk_ready, out_valid, qp_flag, eff_qp, xo, yo, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {blk_ready, out_valid, qp_flag, eff_qp, xo, yo, busy, done});
        end
        for (int i = 0; i < W; i++) begin cb0[i] = 0; cb1[i] = 0; end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < N; i++) begin cbf_a[i] = 0; cbf1_a[i] = 0; qp_a[i] = 30; end
        run_lcu(0, 0, 0);
        checks++;
        if (obs_flag[4] !== 1'b0 || obs_qp[4] !== 6'd30) begin
            failures++; $display("FAIL zero_rowstart got=%b/%0d want=0/30", obs_flag[4], obs_qp[4]);
        end
        checks++;
        if (obs_flag[5] !== 1'b1 || obs_qp[5] !== 6'd30) begin
            failures++; $display("FAIL zero_inherit got=%b/%0d want=1/30", obs_flag[5], obs_qp[5]);
        end
    endtask

    task automatic test_pattern();
        logic [5:0] wq [4];
        logic       wf [4];
        rand_blocks();
        cbf_a[0] = 3'b001; cbf_a[1] = 0; cbf_a[2] = 0; cbf_a[3] = 3'b100;
        qp_a[0] = 20; qp_a[1] = 25; qp_a[2] = 27; qp_a[3] = 33;
        wq[0] = 20; wq[1] = 20; wq[2] = 20; wq[3] = 33;
        wf[0] = 0;  wf[1] = 1;  wf[2] = 1;  wf[3] = 0;
        run_lcu(0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_flag[i] !== wf[i] || obs_qp[i] !== wq[i]) begin
                failures++; $display("FAIL pattern_x%0d got=%b/%0d want=%b/%0d", i, obs_flag[i], obs_qp[i], wf[i], wq[i]);
            end
        end
    endtask

    task automatic test_cross_lcu();
        rand_blocks();
        cbf_a[0] = 0;
        qp_a[0] = 40;
        run_lcu(1, 0, 0);
        checks++;
        if (obs_flag[0] !== 1'b1 || obs_qp[0] !== 6'd33) begin
            failures++; $display("FAIL cross_lcu got=%b/%0d want=1/33", obs_flag[0], obs_qp[0]);
        end
    endtask

    task automatic test_stall();
        rand_blocks();
        run_lcu(1'($urandom_range(0, 1)), 2, 0);
    endtask

    task automatic test_start_in_run();
        rand_blocks();
        run_lcu(1, 1, 1);
    endtask

    task automatic test_mid_reset();
        rand_blocks();
        @(negedge clk);
        start = 1; lav_i = 1; out_ready = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 7; i++) begin
            blk_valid = 1; cbf = cbf_a[i]; cbf1 = cbf1_a[i]; qp = qp_a[i];
            #1;
            checks++;
            if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", done); end
            @(negedge clk);
        end
        blk_valid = 0;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || xo !== 2'd0 || yo !== 2'd0) begin
            failures++;
            $display("FAIL midrst_state busy=%b valid=%b done=%b x=%0d y=%0d want=0", busy, out_valid, done, xo, yo);
        end
        for (int i = 0; i < W; i++) begin cb0[i] = 0; cb1[i] = 0; end
        @(negedge clk);
        rst_n = 1;
        rand_blocks();
        cbf_a[0] = 0; cbf1_a[0] = 0;
        run_lcu(1, 0, 0);
        checks++;
        if (obs_flag[0] !== 1'b1 || obs_qp[0] !== 6'd0) begin
            failures++; $display("FAIL midrst_colbuf got=%b/%0d want=1/0", obs_flag[0], obs_qp[0]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            rand_blocks();
            run_lcu(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_pattern();
        test_cross_lcu();
        test_stall();
        test_start_in_run();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
